// File: rtl/fetch_stage.sv
// Instruction fetch stage: byte PC register feeding a single IF/ID register.
// Optional misaligned-redirect trap is enabled by defining FETCH_MISALIGN_CHK_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [9:0]  imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        fetch_misalign
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;
    logic        halted;
    logic        advance;

    assign imem_addr = pc[11:2];
    assign pc_plus4  = pc + 32'd4;
    assign advance   = fetch_en && !halted && (!id_valid || id_ready);

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_q;

    assign redirect_target = redirect_pc;
    assign halted          = misalign_q;
    assign fetch_misalign  = misalign_q;

    // The trap flag doubles as the halt; only a new redirect can lift it.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (redirect_valid) begin
            misalign_q <= (redirect_pc[1:0] != 2'b00);
        end
    end
`else
    assign redirect_target = {redirect_pc[31:2], 2'b00};
    assign halted          = 1'b0;
    assign fetch_misalign  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            id_valid    <= 1'b0;
            id_instr    <= NOP;
            id_pc       <= 32'h0;
            id_pc_plus4 <= 32'h0;
        end else if (redirect_valid) begin
            pc       <= redirect_target;
            id_valid <= 1'b0;
        end else if (advance) begin
            pc          <= pc_plus4;
            id_valid    <= 1'b1;
            id_instr    <= imem_instr;
            id_pc       <= pc;
            id_pc_plus4 <= pc_plus4;
        end else if (!fetch_en && id_ready) begin
            id_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: reference model plus directed checks.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [9:0]  imem_addr;
    logic [31:0] imem_instr;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        fetch_misalign;

    logic [31:0] mem [1024];

    int checks = 0;
    int errors = 0;
    bit checking = 0;

`ifdef FETCH_MISALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr];

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .fetch_misalign (fetch_misalign)
    );

    // Reference: architectural PC plus the instruction sitting in IF/ID
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;
    logic        m_mis;

    always @(posedge clk) begin
        if (rst) begin
            m_pc    <= 32'h0;
            m_valid <= 1'b0;
            m_instr <= 32'h0000_0013;
            m_ipc   <= 32'h0;
            m_mis   <= 1'b0;
        end else if (redirect_valid) begin
            m_valid <= 1'b0;
            if (CHK) begin
                m_pc  <= redirect_pc;
                m_mis <= (redirect_pc % 4) != 0;
            end else begin
                m_pc <= redirect_pc - (redirect_pc % 4);
            end
        end else if (fetch_en && !m_mis && (!m_valid || id_ready)) begin
            m_valid <= 1'b1;
            m_instr <= mem[(m_pc / 4) % 1024];
            m_ipc   <= m_pc;
            m_pc    <= m_pc + 4;
        end else if (!fetch_en && id_ready) begin
            m_valid <= 1'b0;
        end
    end

    task automatic cmp(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            cmp("model_valid", {31'h0, id_valid}, {31'h0, m_valid});
            cmp("model_addr", {22'h0, imem_addr}, {22'h0, m_pc[11:2]});
            cmp("model_instr", id_instr, m_instr);
            cmp("model_pc", id_pc, m_ipc);
            cmp("model_pc4", id_pc_plus4, (m_valid || m_ipc != 0 ||
                m_instr != 32'h13) ? m_ipc + 4 : 32'h0);
            cmp("model_mis", {31'h0, fetch_misalign}, {31'h0, m_mis});
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic redir(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        cyc();
        redirect_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
        rst = 1'b1;
        fetch_en = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        id_ready = 1'b1;
        cyc();
        checking = 1'b1;
        cyc();
        cmp("rst_valid", {31'h0, id_valid}, 32'h0);
        cmp("rst_instr", id_instr, 32'h0000_0013);
        cmp("rst_addr", {22'h0, imem_addr}, 32'h0);
        cmp("rst_mis", {31'h0, fetch_misalign}, 32'h0);

        rst = 1'b0;
        fetch_en = 1'b1;
        cyc();
        cmp("f0_valid", {31'h0, id_valid}, 32'h1);
        cmp("f0_pc", id_pc, 32'h0);
        cmp("f0_instr", id_instr, 32'h1000_0000);
        cyc();
        cmp("f1_pc", id_pc, 32'h4);
        cmp("f1_instr", id_instr, 32'h1000_0001);
        cyc();
        cmp("f2_pc", id_pc, 32'h8);
        cmp("f2_instr", id_instr, 32'h1000_0002);

        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            cmp("stall_pc", id_pc, 32'h8);
            cmp("stall_instr", id_instr, 32'h1000_0002);
            cmp("stall_addr", {22'h0, imem_addr}, 32'h3);
        end
        id_ready = 1'b1;
        cyc();
        cmp("unstall_pc", id_pc, 32'hC);

        id_ready = 1'b0;
        redir(32'h0000_0100);
        cmp("redir_valid", {31'h0, id_valid}, 32'h0);
        cmp("redir_addr", {22'h0, imem_addr}, 32'h40);
        id_ready = 1'b1;
        cyc();
        cmp("redir_pc", id_pc, 32'h100);

        redir(32'h0000_0FFC);
        cmp("wrap_addr0", {22'h0, imem_addr}, 32'h3FF);
        cyc();
        cmp("wrap_pc", id_pc, 32'hFFC);
        cmp("wrap_addr1", {22'h0, imem_addr}, 32'h0);
        cmp("wrap_pc4", id_pc_plus4, 32'h0000_1000);

        redir(32'hFFFF_FFFC);
        cyc();
        cmp("wrap32_pc4", id_pc_plus4, 32'h0);

        fetch_en = 1'b0;
        cyc();
        cmp("noen_valid", {31'h0, id_valid}, 32'h0);
        cyc();
        cmp("noen_addr", {22'h0, imem_addr}, 32'h0);
        fetch_en = 1'b1;

        redir(32'h0000_0102);
        if (CHK) begin
            cmp("mis_flag", {31'h0, fetch_misalign}, 32'h1);
            cyc();
            cyc();
            cmp("mis_halt", {31'h0, id_valid}, 32'h0);
        end else begin
            cmp("mis_flag0", {31'h0, fetch_misalign}, 32'h0);
            cmp("mis_addr", {22'h0, imem_addr}, 32'h40);
            cyc();
            cmp("mis_pc", id_pc, 32'h100);
        end
        redir(32'h0000_0200);
        cmp("clr_flag", {31'h0, fetch_misalign}, 32'h0);
        cyc();
        cmp("clr_pc", id_pc, 32'h200);

        redir(32'h0000_0204);
        cmp("same_valid", {31'h0, id_valid}, 32'h0);
        cyc();
        cmp("same_pc", id_pc, 32'h204);

        id_ready = 1'b0;
        rst = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0300;
        cyc();
        cmp("rstov_valid", {31'h0, id_valid}, 32'h0);
        cmp("rstov_addr", {22'h0, imem_addr}, 32'h0);
        rst = 1'b0;
        redirect_valid = 1'b0;

        for (int i = 0; i < 60; i++) begin
            fetch_en = (i % 7) != 3;
            id_ready = (i % 5) < 3;
            redirect_valid = (i % 11) == 6;
            redirect_pc = 32'h400 + 32'(i) * 8;
            cyc();
        end
        redirect_valid = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
